// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_e     : FSM state encoding (IDLE=0, DATA=1, INSTR=2, DONE=3)
//   ABORT_DATA  : value captured when an access times out
//   CNT_W       : width of the bus-wait timeout counter
package mem_arb_pkg;

    localparam int          CNT_W      = 10;
    localparam logic [31:0] ABORT_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared single-ported memory bus between the arbiter (master) and the
// SoC interconnect (slave).
//   bus_req_o / bus_we_o / bus_addr_o / bus_wdata_o / bus_be_o : master -> slave
//   bus_rdata_i / bus_ack_i                                     : slave -> master
//
// Handshake: the master raises bus_req_o together with the address, write
// data, byte enables and bus_we_o and holds all of them unchanged until the
// cycle in which the slave returns bus_ack_i=1; that cycle completes the
// transfer and bus_rdata_i is valid only in it. On the following edge the
// master either drops bus_req_o or presents the next access. A request may
// also be withdrawn without an ack by reset or by the master's timeout.
interface mem_port_arbiter_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_rdata_i, bus_ack_i
    );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Bus-wait timeout counter.
//   clk_i, rst_i : clock, synchronous active-low reset
//   clear_i      : restart counting from zero (no access outstanding, or acked)
//   enable_i     : a request is waiting without an ack this cycle
//   limit_i      : number of waiting cycles allowed
//   expired_o    : this waiting cycle is the limit_i-th one; abort the access
module arb_timeout_counter
    import mem_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Flag the cycle in which the increment would reach the limit, so the
    // request stays up for exactly limit_i cycles.
    assign expired_o = enable_i && (({1'b0, cnt_q} + 1'b1) == {1'b0, limit_i});

    always_comb begin
        cnt_d = cnt_q;
        // Self-clear on expiry so a following access starts from zero even
        // though the bus request never dropped in between.
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the CPU data access and instruction fetch of one pipeline step
// onto a single memory bus (data first, then fetch) and pulses mem_ready_o
// once both have finished.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   instr_*               : fetch request / address / fetched instruction
//   data_*                : data read/write request, address, write data,
//                           byte enables, read data
//   mem_ready_o           : one-cycle step-complete strobe
//   error_o               : sticky bus-timeout flag
//   bus                   : shared memory bus (master side)
//   state_o               : current FSM state, for observation
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_rd_i,
    input  logic [31:0]         instr_addr_i,
    output logic [31:0]         instr_data_o,
    input  logic                data_rd_i,
    input  logic                data_wr_i,
    input  logic [31:0]         data_addr_i,
    input  logic [31:0]         data_wdata_i,
    input  logic [3:0]          data_be_i,
    output logic [31:0]         data_rdata_o,
    output logic                mem_ready_o,
    output logic                error_o,
    mem_port_arbiter_if.master  bus,
    output state_e              state_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic        instr_rd_q, instr_rd_d;
    logic [31:0] instr_addr_q, instr_addr_d;
    logic        data_rd_q, data_rd_d;
    logic        data_wr_q, data_wr_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [3:0]  data_be_q, data_be_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic        error_q, error_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;

    logic expired;
    logic done;

    // Request as seen this cycle: the live inputs while they are being
    // captured in IDLE, the captured copy afterwards.
    logic        eff_wr;
    logic [31:0] eff_daddr, eff_wdata, eff_iaddr;
    logic [3:0]  eff_be;

    arb_timeout_counter u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!bus_req_q || bus.bus_ack_i),
        .enable_i  (bus_req_q && !bus.bus_ack_i),
        .limit_i   (LIMIT),
        .expired_o (expired)
    );

    assign done = bus.bus_ack_i || expired;

    always_comb begin
        state_d      = state_q;
        instr_rd_d   = instr_rd_q;
        instr_addr_d = instr_addr_q;
        data_rd_d    = data_rd_q;
        data_wr_d    = data_wr_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_be_d    = data_be_q;
        instr_data_d = instr_data_q;
        data_rdata_d = data_rdata_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                instr_rd_d   = instr_rd_i;
                instr_addr_d = instr_addr_i;
                data_rd_d    = data_rd_i;
                data_wr_d    = data_wr_i;
                data_addr_d  = data_addr_i;
                data_wdata_d = data_wdata_i;
                data_be_d    = data_be_i;
                if (data_rd_i || data_wr_i) begin
                    state_d = DATA;
                end else if (instr_rd_i) begin
                    state_d = INSTR;
                end else begin
                    state_d = DONE;
                end
            end
            DATA: begin
                if (done) begin
                    // A plain write leaves the read data alone; a combined
                    // read+write is performed as a write and reads back zero.
                    if (data_wr_q) begin
                        if (data_rd_q) begin
                            data_rdata_d = 32'h0;
                        end
                    end else begin
                        data_rdata_d = bus.bus_ack_i ? bus.bus_rdata_i : ABORT_DATA;
                    end
                    if (expired) begin
                        error_d = 1'b1;
                    end
                    state_d = instr_rd_q ? INSTR : DONE;
                end
            end
            INSTR: begin
                if (done) begin
                    instr_data_d = bus.bus_ack_i ? bus.bus_rdata_i : ABORT_DATA;
                    if (expired) begin
                        error_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        eff_wr    = (state_q == IDLE) ? data_wr_i    : data_wr_q;
        eff_daddr = (state_q == IDLE) ? data_addr_i  : data_addr_q;
        eff_wdata = (state_q == IDLE) ? data_wdata_i : data_wdata_q;
        eff_be    = (state_q == IDLE) ? data_be_i    : data_be_q;
        eff_iaddr = (state_q == IDLE) ? instr_addr_i : instr_addr_q;
    end

    // Bus outputs are registered, so they are derived from the state being
    // entered; values recompute identically while a request waits.
    always_comb begin
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = 32'h0;
        bus_wdata_d = 32'h0;
        bus_be_d    = 4'h0;
        mem_ready_d = (state_d == DONE);
        case (state_d)
            DATA: begin
                bus_req_d   = 1'b1;
                bus_we_d    = eff_wr;
                bus_addr_d  = eff_daddr;
                bus_wdata_d = eff_wdata;
                bus_be_d    = eff_wr ? eff_be : 4'hF;
            end
            INSTR: begin
                bus_req_d   = 1'b1;
                bus_addr_d  = eff_iaddr;
                bus_be_d    = 4'hF;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            instr_rd_q   <= 1'b0;
            instr_addr_q <= 32'h0;
            data_rd_q    <= 1'b0;
            data_wr_q    <= 1'b0;
            data_addr_q  <= 32'h0;
            data_wdata_q <= 32'h0;
            data_be_q    <= 4'h0;
            instr_data_q <= 32'h0;
            data_rdata_q <= 32'h0;
            mem_ready_q  <= 1'b0;
            error_q      <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_be_q     <= 4'h0;
        end else begin
            state_q      <= state_d;
            instr_rd_q   <= instr_rd_d;
            instr_addr_q <= instr_addr_d;
            data_rd_q    <= data_rd_d;
            data_wr_q    <= data_wr_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_be_q    <= data_be_d;
            instr_data_q <= instr_data_d;
            data_rdata_q <= data_rdata_d;
            mem_ready_q  <= mem_ready_d;
            error_q      <= error_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
        end
    end

    assign instr_data_o    = instr_data_q;
    assign data_rdata_o    = data_rdata_q;
    assign mem_ready_o     = mem_ready_q;
    assign error_o         = error_q;
    assign state_o         = state_q;
    assign bus.bus_req_o   = bus_req_q;
    assign bus.bus_we_o    = bus_we_q;
    assign bus.bus_addr_o  = bus_addr_q;
    assign bus.bus_wdata_o = bus_wdata_q;
    assign bus.bus_be_o    = bus_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        instr_rd_i;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_data_o;
    logic        data_rd_i;
    logic        data_wr_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_rdata_o;
    logic        mem_ready_o;
    logic        error_o;
    state_e      state_o;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .instr_rd_i   (instr_rd_i),
        .instr_addr_i (instr_addr_i),
        .instr_data_o (instr_data_o),
        .data_rd_i    (data_rd_i),
        .data_wr_i    (data_wr_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_be_i    (data_be_i),
        .data_rdata_o (data_rdata_o),
        .mem_ready_o  (mem_ready_o),
        .error_o      (error_o),
        .bus          (bus.master),
        .state_o      (state_o)
    );

    int checks = 0;
    int fails  = 0;

    // ---------------- bus slave model ----------------
    bit          slave_en    = 1'b1;
    bit          force_ack   = 1'b0;
    int          slave_waits = 0;
    int          wcnt        = 0;
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_wdata_q[$];
    logic        obs_we_q[$];
    logic [3:0]  obs_be_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_2000: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    initial begin
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
    end

    always @(posedge clk) begin
        #2;
        if (force_ack) begin
            bus.bus_ack_i   = 1'b1;
            bus.bus_rdata_i = 32'hBAD0_BAD0;
            wcnt = 0;
        end else if (slave_en && bus.bus_req_o) begin
            if (wcnt >= slave_waits) begin
                bus.bus_ack_i   = 1'b1;
                bus.bus_rdata_i = mem_model(bus.bus_addr_o);
                obs_addr_q.push_back(bus.bus_addr_o);
                obs_wdata_q.push_back(bus.bus_wdata_o);
                obs_we_q.push_back(bus.bus_we_o);
                obs_be_q.push_back(bus.bus_be_o);
                wcnt = 0;
            end else begin
                bus.bus_ack_i   = 1'b0;
                bus.bus_rdata_i = 32'h0;
                wcnt++;
            end
        end else begin
            bus.bus_ack_i   = 1'b0;
            bus.bus_rdata_i = 32'h0;
            wcnt = 0;
        end
    end

    // ---------------- protocol monitors ----------------
    int          stab_err  = 0;
    int          consec_err = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0, prev_ready = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
    logic [3:0]  prev_be = 4'h0;

    always @(negedge clk) begin
        if (bus.bus_req_o && prev_req && !prev_ack) begin
            if (bus.bus_addr_o !== prev_addr || bus.bus_we_o !== prev_we ||
                bus.bus_be_o !== prev_be || bus.bus_wdata_o !== prev_wdata)
                stab_err++;
        end
        prev_req   = bus.bus_req_o;
        prev_ack   = bus.bus_ack_i;
        prev_we    = bus.bus_we_o;
        prev_addr  = bus.bus_addr_o;
        prev_wdata = bus.bus_wdata_o;
        prev_be    = bus.bus_be_o;
        if (mem_ready_o && prev_ready) consec_err++;
        prev_ready = mem_ready_o;
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic rd, input logic wr, input logic [31:0] daddr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic ird, input logic [31:0] iaddr);
        data_rd_i    = rd;
        data_wr_i    = wr;
        data_addr_i  = daddr;
        data_wdata_i = wdata;
        data_be_i    = be;
        instr_rd_i   = ird;
        instr_addr_i = iaddr;
        obs_addr_q.delete();
        obs_wdata_q.delete();
        obs_we_q.delete();
        obs_be_q.delete();
    endtask

    // Counts negedges until mem_ready_o is seen; -1 if it never comes.
    task automatic wait_pulse(output int cycles, output int req_cycles);
        bit found;
        found = 1'b0;
        cycles = -1;
        req_cycles = 0;
        for (int i = 1; i <= 64 && !found; i++) begin
            @(negedge clk);
            if (bus.bus_req_o) req_cycles++;
            if (mem_ready_o) begin
                cycles = i;
                found = 1'b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (bus.bus_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", bus.bus_req_o); end
        checks++; if (mem_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", mem_ready_o); end
        checks++; if (error_o !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error_o); end
        checks++; if (bus.bus_addr_o !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bus.bus_addr_o); end
        checks++; if (instr_data_o !== 32'h0 || data_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_data: got %h/%h expected 0/0", instr_data_o, data_rdata_o); end
        checks++; if (state_o !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_idle();
        int cyc, req;
        rst_i = 1'b1;
        wait_pulse(cyc, req);
        checks++; if (cyc !== 1) begin fails++; $display("FAIL idle_first: got %0d expected 1", cyc); end
        for (int k = 0; k < 2; k++) begin
            wait_pulse(cyc, req);
            checks++; if (cyc !== 2) begin fails++; $display("FAIL idle_period: got %0d expected 2", cyc); end
            checks++; if (req !== 0) begin fails++; $display("FAIL idle_req: got %0d expected 0", req); end
        end
    endtask

    task automatic test_fetch();
        int cyc, req;
        slave_waits = 0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100);
        wait_pulse(cyc, req);
        checks++; if (cyc !== 3) begin fails++; $display("FAIL fetch_latency: got %0d expected 3", cyc); end
        checks++; if (instr_data_o !== 32'h0050_0093) begin fails++; $display("FAIL fetch_data: got %h expected 00500093", instr_data_o); end
        checks++;
        if (obs_addr_q.size() !== 1) begin fails++; $display("FAIL fetch_count: got %0d expected 1", obs_addr_q.size()); end
        else if (obs_addr_q[0] !== 32'h100 || obs_we_q[0] !== 1'b0 || obs_be_q[0] !== 4'hF) begin
            fails++; $display("FAIL fetch_bus: got addr %h we %b be %h expected 100/0/f", obs_addr_q[0], obs_we_q[0], obs_be_q[0]);
        end
        obs_addr_q.delete();
        wait_pulse(cyc, req);
        checks++; if (cyc !== 3) begin fails++; $display("FAIL fetch_period: got %0d expected 3", cyc); end
    endtask

    task automatic test_load_fetch();
        int cyc, req;
        slave_waits = 2;
        set_req(1'b1, 1'b0, 32'h2000, 32'h0, 4'h3, 1'b1, 32'h104);
        exp_q = '{32'h2000, 32'h104};
        wait_pulse(cyc, req);
        checks++; if (cyc !== 8) begin fails++; $display("FAIL load_latency: got %0d expected 8", cyc); end
        checks++; if (data_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_rdata: got %h expected deadbeef", data_rdata_o); end
        checks++; if (instr_data_o !== 32'h00A0_0113) begin fails++; $display("FAIL load_instr: got %h expected 00a00113", instr_data_o); end
        checks++; if (obs_addr_q.size() !== 2) begin fails++; $display("FAIL load_count: got %0d expected 2", obs_addr_q.size()); end
        for (int i = 0; i < 2 && i < obs_addr_q.size(); i++) begin
            checks++;
            if (obs_addr_q[i] !== exp_q[i] || obs_be_q[i] !== 4'hF || obs_we_q[i] !== 1'b0) begin
                fails++; $display("FAIL load_order: txn %0d got %h be %h expected %h be f", i, obs_addr_q[i], obs_be_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_store();
        int cyc, req;
        slave_waits = 1;
        set_req(1'b0, 1'b1, 32'h3000, 32'h00AB_0000, 4'b0100, 1'b0, 32'h0);
        wait_pulse(cyc, req);
        checks++; if (cyc !== 4) begin fails++; $display("FAIL store_latency: got %0d expected 4", cyc); end
        checks++; if (data_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_rdata_kept: got %h expected deadbeef", data_rdata_o); end
        checks++;
        if (obs_addr_q.size() !== 1) begin fails++; $display("FAIL store_count: got %0d expected 1", obs_addr_q.size()); end
        else if (obs_addr_q[0] !== 32'h3000 || obs_we_q[0] !== 1'b1 || obs_be_q[0] !== 4'b0100 || obs_wdata_q[0] !== 32'h00AB_0000) begin
            fails++; $display("FAIL store_bus: got %h/%b/%h/%h expected 3000/1/4/00ab0000", obs_addr_q[0], obs_we_q[0], obs_be_q[0], obs_wdata_q[0]);
        end
        checks++; if (stab_err !== 0) begin fails++; $display("FAIL store_stable: got %0d changes expected 0", stab_err); end
    endtask

    task automatic test_rd_wr_both();
        int cyc, req;
        slave_waits = 0;
        set_req(1'b1, 1'b1, 32'h3004, 32'h1234_5678, 4'hF, 1'b1, 32'h10C);
        wait_pulse(cyc, req);
        checks++; if (cyc !== 4) begin fails++; $display("FAIL both_latency: got %0d expected 4", cyc); end
        checks++; if (data_rdata_o !== 32'h0) begin fails++; $display("FAIL both_rdata: got %h expected 0", data_rdata_o); end
        checks++; if (instr_data_o !== 32'h5A5A_5B56) begin fails++; $display("FAIL both_instr: got %h expected 5a5a5b56", instr_data_o); end
        checks++;
        if (obs_addr_q.size() !== 2) begin fails++; $display("FAIL both_count: got %0d expected 2", obs_addr_q.size()); end
        else if (obs_we_q[0] !== 1'b1 || obs_addr_q[0] !== 32'h3004 || obs_we_q[1] !== 1'b0 || obs_addr_q[1] !== 32'h10C) begin
            fails++; $display("FAIL both_bus: got %h/%b then %h/%b expected 3004/1 then 10c/0", obs_addr_q[0], obs_we_q[0], obs_addr_q[1], obs_we_q[1]);
        end
    endtask

    task automatic test_timeout();
        int cyc, req;
        slave_en = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200);
        wait_pulse(cyc, req);
        checks++; if (req !== 4) begin fails++; $display("FAIL timeout_req_len: got %0d expected 4", req); end
        checks++; if (cyc !== 6) begin fails++; $display("FAIL timeout_latency: got %0d expected 6", cyc); end
        checks++; if (instr_data_o !== 32'h0) begin fails++; $display("FAIL timeout_data: got %h expected 0", instr_data_o); end
        checks++; if (error_o !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b expected 1", error_o); end
        slave_en = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100);
        wait_pulse(cyc, req);
        checks++; if (cyc !== 3) begin fails++; $display("FAIL after_timeout_latency: got %0d expected 3", cyc); end
        checks++; if (error_o !== 1'b1) begin fails++; $display("FAIL error_sticky: got %b expected 1", error_o); end
        checks++; if (instr_data_o !== 32'h0050_0093) begin fails++; $display("FAIL after_timeout_data: got %h expected 00500093", instr_data_o); end
    endtask

    task automatic test_reset_mid();
        int cyc, req;
        slave_waits = 20;
        set_req(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.bus_req_o !== 1'b1 || bus.bus_addr_o !== 32'h2000) begin fails++; $display("FAIL mid_req_up: got %b/%h expected 1/2000", bus.bus_req_o, bus.bus_addr_o); end
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.bus_req_o !== 1'b0) begin fails++; $display("FAIL mid_req_drop: got %b expected 0", bus.bus_req_o); end
        checks++; if (error_o !== 1'b0 || mem_ready_o !== 1'b0) begin fails++; $display("FAIL mid_reset_flags: got err %b rdy %b expected 0/0", error_o, mem_ready_o); end
        checks++; if (state_o !== IDLE) begin fails++; $display("FAIL mid_reset_state: got %0d expected 0", state_o); end
        force_ack = 1'b1;
        @(negedge clk);
        force_ack   = 1'b0;
        slave_waits = 0;
        rst_i       = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h104);
        wait_pulse(cyc, req);
        checks++; if (cyc !== 2) begin fails++; $display("FAIL mid_new_latency: got %0d expected 2", cyc); end
        checks++; if (instr_data_o !== 32'h00A0_0113) begin fails++; $display("FAIL mid_new_data: got %h expected 00a00113", instr_data_o); end
        checks++;
        if (obs_addr_q.size() !== 1) begin fails++; $display("FAIL mid_count: got %0d expected 1", obs_addr_q.size()); end
        else if (obs_addr_q[0] !== 32'h104) begin fails++; $display("FAIL mid_first_addr: got %h expected 104", obs_addr_q[0]); end
    endtask

    task automatic test_protocol();
        checks++; if (consec_err !== 0) begin fails++; $display("FAIL ready_consecutive: got %0d expected 0", consec_err); end
        checks++; if (stab_err !== 0) begin fails++; $display("FAIL bus_stable: got %0d expected 0", stab_err); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_i = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        test_reset();
        test_idle();
        test_fetch();
        test_load_fetch();
        test_store();
        test_rd_wr_both();
        test_timeout();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
